// File: rtl/soric_data_xbar.sv
// Data-bus crossbar: NCORE OBI-style masters onto NSRAM single-cycle SRAM banks with per-bank round-robin.
// Optional per-bank conflict counters are built when SORIC_XBAR_PERF_EN is defined.
module soric_data_xbar #(
  parameter int unsigned NCORE       = 2,
  parameter int unsigned NSRAM       = 4,
  parameter int unsigned D_ADDR_W    = 14,
  parameter int unsigned SRAM_ADDR_W = 11
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [NCORE-1:0]             m_req_i,
  input  logic [NCORE*D_ADDR_W-1:0]    m_addr_i,
  input  logic [NCORE-1:0]             m_we_i,
  input  logic [NCORE*4-1:0]           m_be_i,
  input  logic [NCORE*32-1:0]          m_wdata_i,
  output logic [NCORE-1:0]             m_gnt_o,
  output logic [NCORE-1:0]             m_rvalid_o,
  output logic [NCORE*32-1:0]          m_rdata_o,
  output logic [NCORE-1:0]             m_err_o,
  output logic [NSRAM-1:0]             s_req_o,
  output logic [NSRAM*SRAM_ADDR_W-1:0] s_addr_o,
  output logic [NSRAM-1:0]             s_we_o,
  output logic [NSRAM*4-1:0]           s_be_o,
  output logic [NSRAM*32-1:0]          s_wdata_o,
  input  logic [NSRAM*32-1:0]          s_rdata_i,
  output logic [NSRAM*16-1:0]          conflict_cnt_o
);

  localparam int unsigned BANK_W = (NSRAM > 1) ? $clog2(NSRAM) : 1;
  localparam int unsigned PTR_W  = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int unsigned HI_LSB = SRAM_ADDR_W + BANK_W;

  logic [D_ADDR_W-1:0] m_addr   [NCORE];
  logic [BANK_W-1:0]   m_bank   [NCORE];
  logic [NCORE-1:0]    m_oor;
  logic [NCORE-1:0]    bank_req [NSRAM];
  logic [NSRAM-1:0]    bank_hit;
  logic [PTR_W-1:0]    bank_win [NSRAM];
  logic [PTR_W-1:0]    ptr_q    [NSRAM];
  logic [PTR_W-1:0]    ptr_d    [NSRAM];
  logic [NCORE-1:0]    gnt;

  logic [NCORE-1:0]    rsp_pending_q, rsp_pending_d;
  logic [NCORE-1:0]    rsp_err_q, rsp_err_d;
  logic [NCORE-1:0]    rsp_we_q;
  logic [BANK_W-1:0]   rsp_bank_q [NCORE];

  // Address decode: bank field plus an out-of-range flag for any bit above it.
  always_comb begin
    for (int unsigned m = 0; m < NCORE; m++) begin
      m_addr[m] = m_addr_i[m*D_ADDR_W +: D_ADDR_W];
      m_bank[m] = m_addr[m][SRAM_ADDR_W +: BANK_W];
      m_oor[m]  = |(m_addr[m] >> HI_LSB);
    end
    for (int unsigned b = 0; b < NSRAM; b++) begin
      for (int unsigned m = 0; m < NCORE; m++) begin
        bank_req[b][m] = m_req_i[m] & ~m_oor[m] & (m_bank[m] == BANK_W'(b));
      end
    end
  end

  // Per-bank round-robin: first requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    int unsigned w;
    idx       = 0;
    w         = 0;
    gnt       = m_req_i & m_oor;
    bank_hit  = '0;
    s_req_o   = '0;
    s_addr_o  = '0;
    s_we_o    = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    for (int unsigned b = 0; b < NSRAM; b++) begin
      bank_win[b] = '0;
      ptr_d[b]    = ptr_q[b];
    end
    for (int unsigned b = 0; b < NSRAM; b++) begin
      for (int unsigned k = 0; k < NCORE; k++) begin
        idx = 32'(ptr_q[b]) + k;
        if (idx >= NCORE) idx = idx - NCORE;
        if (!bank_hit[b] && bank_req[b][idx]) begin
          bank_hit[b] = 1'b1;
          bank_win[b] = PTR_W'(idx);
        end
      end
      if (bank_hit[b]) begin
        w = 32'(bank_win[b]);
        gnt[w] = 1'b1;
        s_req_o[b]                            = 1'b1;
        s_addr_o[b*SRAM_ADDR_W +: SRAM_ADDR_W] = m_addr[w][SRAM_ADDR_W-1:0];
        s_we_o[b]                             = m_we_i[w];
        s_be_o[b*4 +: 4]                      = m_be_i[w*4 +: 4];
        s_wdata_o[b*32 +: 32]                 = m_wdata_i[w*32 +: 32];
        ptr_d[b] = (w + 1 >= NCORE) ? '0 : PTR_W'(w + 1);
      end
    end
  end

  assign m_gnt_o       = gnt;
  assign rsp_pending_d = gnt;
  assign rsp_err_d     = m_req_i & m_oor;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp_pending_q <= '0;
      rsp_err_q     <= '0;
      rsp_we_q      <= '0;
      for (int unsigned m = 0; m < NCORE; m++) rsp_bank_q[m] <= '0;
      for (int unsigned b = 0; b < NSRAM; b++) ptr_q[b] <= '0;
    end else begin
      rsp_pending_q <= rsp_pending_d;
      rsp_err_q     <= rsp_err_d;
      rsp_we_q      <= m_we_i;
      for (int unsigned m = 0; m < NCORE; m++) rsp_bank_q[m] <= m_bank[m];
      for (int unsigned b = 0; b < NSRAM; b++) ptr_q[b] <= ptr_d[b];
    end
  end

  // Read data only for in-range reads; writes and errors return zero.
  always_comb begin
    m_rdata_o = '0;
    for (int unsigned m = 0; m < NCORE; m++) begin
      if (rsp_pending_q[m] && !rsp_err_q[m] && !rsp_we_q[m]) begin
        m_rdata_o[m*32 +: 32] = s_rdata_i[32'(rsp_bank_q[m])*32 +: 32];
      end
    end
  end

  assign m_rvalid_o = rsp_pending_q;
  assign m_err_o    = rsp_err_q;

`ifdef SORIC_XBAR_PERF_EN
  logic [NSRAM-1:0] conflict;
  logic [15:0]      cnt_q [NSRAM];

  always_comb begin
    conflict = '0;
    for (int unsigned b = 0; b < NSRAM; b++) begin
      conflict[b] = |(bank_req[b] & ~(NCORE'(1) << bank_win[b]));
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int unsigned b = 0; b < NSRAM; b++) cnt_q[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < NSRAM; b++) begin
        if (conflict[b] && (cnt_q[b] != 16'hFFFF)) cnt_q[b] <= cnt_q[b] + 16'd1;
      end
    end
  end

  always_comb begin
    conflict_cnt_o = '0;
    for (int unsigned b = 0; b < NSRAM; b++) conflict_cnt_o[b*16 +: 16] = cnt_q[b];
  end
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_soric_data_xbar.sv
// Randomized and directed bench for soric_data_xbar against a transaction-level reference model.
module tb_soric_data_xbar;
  localparam int NCORE = 2;
  localparam int NSRAM = 4;
  localparam int DAW   = 14;
  localparam int SAW   = 11;
  localparam int BANK_BYTES = 2048;

  logic                   clk = 1'b0;
  logic                   wb_rst_i;
  logic [NCORE-1:0]       m_req_i;
  logic [NCORE*DAW-1:0]   m_addr_i;
  logic [NCORE-1:0]       m_we_i;
  logic [NCORE*4-1:0]     m_be_i;
  logic [NCORE*32-1:0]    m_wdata_i;
  logic [NCORE-1:0]       m_gnt_o, m_rvalid_o, m_err_o;
  logic [NCORE*32-1:0]    m_rdata_o;
  logic [NSRAM-1:0]       s_req_o, s_we_o;
  logic [NSRAM*SAW-1:0]   s_addr_o;
  logic [NSRAM*4-1:0]     s_be_o;
  logic [NSRAM*32-1:0]    s_wdata_o;
  logic [NSRAM*32-1:0]    s_rdata_i;
  logic [NSRAM*16-1:0]    conflict_cnt_o;

  always #5 clk = ~clk;

  soric_data_xbar #(.NCORE(NCORE), .NSRAM(NSRAM), .D_ADDR_W(DAW), .SRAM_ADDR_W(SAW)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .conflict_cnt_o(conflict_cnt_o)
  );

  // Behavioural SRAM banks, one-cycle read latency.
  logic [31:0] sram [NSRAM][512];
  always @(posedge clk) begin
    for (int b = 0; b < NSRAM; b++) begin
      if (s_req_o[b]) begin
        automatic int w = int'(s_addr_o[b*SAW+2 +: 9]);
        if (s_we_o[b]) begin
          for (int i = 0; i < 4; i++)
            if (s_be_o[b*4+i]) sram[b][w][i*8 +: 8] <= s_wdata_o[b*32+i*8 +: 8];
        end else begin
          s_rdata_i[b*32 +: 32] <= sram[b][w];
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int               ptr [NSRAM];
  int               cnt [NSRAM];
  logic [31:0]      ref_mem [NSRAM*512];
  logic [NCORE-1:0] exp_rvalid, exp_err;
  logic [NCORE*32-1:0] exp_rdata;
  logic [NCORE-1:0] mdl_gnt;
  logic [NCORE-1:0] obs_gnt;
  logic [NSRAM-1:0] obs_sreq;

  task automatic model_reset();
    for (int b = 0; b < NSRAM; b++) begin ptr[b] = 0; cnt[b] = 0; end
    exp_rvalid = '0; exp_err = '0; exp_rdata = '0; mdl_gnt = '0;
  endtask

  task automatic setm(input int m, input logic req, input logic [DAW-1:0] a, input logic we,
                      input logic [3:0] be, input logic [31:0] wd);
    m_req_i[m] = req;
    m_addr_i[m*DAW +: DAW] = a;
    m_we_i[m] = we;
    m_be_i[m*4 +: 4] = be;
    m_wdata_i[m*32 +: 32] = wd;
  endtask

  // One bus cycle: called at negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    int a [NCORE];
    logic [NCORE-1:0] oor, eg;
    int win [NSRAM];
    int ncand [NSRAM];
    logic [NSRAM-1:0] esr, ewe;
    logic [NSRAM*SAW-1:0] esa;
    logic [NSRAM*4-1:0] ebe;
    logic [NSRAM*32-1:0] ewd;
    logic [NSRAM*16-1:0] ecc;
    #1;
    check_eq("rvalid", m_rvalid_o, exp_rvalid);
    check_eq("err", m_err_o, exp_err);
    check_eq("rdata", m_rdata_o, exp_rdata);
    for (int m = 0; m < NCORE; m++) begin
      a[m] = int'(m_addr_i[m*DAW +: DAW]);
      oor[m] = (a[m] >= NSRAM*BANK_BYTES);
    end
    eg = m_req_i & oor;
    esr = '0; ewe = '0; esa = '0; ebe = '0; ewd = '0; ecc = '0;
    for (int b = 0; b < NSRAM; b++) begin
      win[b] = -1; ncand[b] = 0;
      for (int k = 0; k < NCORE; k++) begin
        automatic int m = (ptr[b] + k) % NCORE;
        if (m_req_i[m] && !oor[m] && a[m] / BANK_BYTES == b) begin
          ncand[b]++;
          if (win[b] < 0) win[b] = m;
        end
      end
      if (win[b] >= 0) begin
        eg[win[b]] = 1'b1;
        esr[b] = 1'b1;
        esa[b*SAW +: SAW] = SAW'(a[win[b]] % BANK_BYTES);
        ewe[b] = m_we_i[win[b]];
        ebe[b*4 +: 4] = m_be_i[win[b]*4 +: 4];
        ewd[b*32 +: 32] = m_wdata_i[win[b]*32 +: 32];
      end
`ifdef SORIC_XBAR_PERF_EN
      ecc[b*16 +: 16] = 16'(cnt[b]);
`endif
    end
    obs_gnt = m_gnt_o;
    obs_sreq = s_req_o;
    check_eq("gnt", m_gnt_o, eg);
    check_eq("s_req", s_req_o, esr);
    check_eq("s_addr", s_addr_o, esa);
    check_eq("s_we", s_we_o, ewe);
    check_eq("s_be", s_be_o, ebe);
    check_eq("s_wdata", s_wdata_o, ewd);
    check_eq("conflict_cnt", conflict_cnt_o, ecc);
    @(posedge clk);
    mdl_gnt = eg;
    exp_rvalid = eg;
    exp_err = eg & oor;
    exp_rdata = '0;
    for (int m = 0; m < NCORE; m++)
      if (eg[m] && !oor[m] && !m_we_i[m]) exp_rdata[m*32 +: 32] = ref_mem[a[m] / 4];
    for (int m = 0; m < NCORE; m++)
      if (eg[m] && !oor[m] && m_we_i[m])
        for (int i = 0; i < 4; i++)
          if (m_be_i[m*4+i]) ref_mem[a[m] / 4][i*8 +: 8] = m_wdata_i[m*32+i*8 +: 8];
    for (int b = 0; b < NSRAM; b++) begin
      if (win[b] >= 0) ptr[b] = (win[b] + 1) % NCORE;
      if (ncand[b] > 1 && cnt[b] < 16'hFFFF) cnt[b]++;
    end
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int m = 0; m < NCORE; m++) setm(m, 1'b0, '0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic rst_cycle();
    wb_rst_i = 1'b1;
    idle_all();
    @(posedge clk);
    model_reset();
    @(negedge clk);
    wb_rst_i = 1'b0;
  endtask

  initial begin
    wb_rst_i = 1'b1;
    m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
    for (int i = 0; i < NSRAM*512; i++) ref_mem[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("reset_rvalid", m_rvalid_o, '0);
    check_eq("reset_err", m_err_o, '0);
    check_eq("reset_rdata", m_rdata_o, '0);
    check_eq("reset_s_req", s_req_o, '0);
    check_eq("reset_gnt", m_gnt_o, '0);
    @(negedge clk);
    wb_rst_i = 1'b0;

    // Fill the first eight words of every bank so later reads are defined.
    for (int b = 0; b < NSRAM; b++)
      for (int w = 0; w < 8; w++) begin
        setm(0, 1'b1, DAW'(b*BANK_BYTES + w*4), 1'b1, 4'hF, $urandom);
        step();
      end
    idle_all(); step();

    // Write then read back through bank 1.
    setm(0, 1'b1, 14'h0804, 1'b1, 4'hF, 32'hCAFE_0001); step();
    check_eq("t1_wr_rvalid", m_rvalid_o[0], 1'b1);
    setm(0, 1'b1, 14'h0804, 1'b0, 4'hF, 32'h0); step();
    check_eq("t1_rd_rvalid", m_rvalid_o[0], 1'b1);
    check_eq("t1_rd_rdata", m_rdata_o[31:0], 32'hCAFE_0001);
    check_eq("t1_rd_err", m_err_o[0], 1'b0);
    idle_all(); step();

    // Continuous contention on bank 2 from a reset pointer.
    rst_cycle();
    setm(0, 1'b1, 14'h1000, 1'b0, 4'hF, 32'h0);
    setm(1, 1'b1, 14'h1010, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("t2_alt_gnt", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle_all(); step();
`ifdef SORIC_XBAR_PERF_EN
    check_eq("t2_conflict_cnt2", conflict_cnt_o[2*16 +: 16], 16'd6);
`endif

    // Different banks in the same cycle.
    setm(0, 1'b1, 14'h0000, 1'b0, 4'hF, 32'h0);
    setm(1, 1'b1, 14'h1800, 1'b0, 4'hF, 32'h0);
    step();
    check_eq("t3_s_req", obs_sreq, 4'b1001);
    check_eq("t3_rvalid", m_rvalid_o, 2'b11);

    // Out-of-range access.
    setm(0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    setm(1, 1'b1, 14'h2000, 1'b0, 4'hF, 32'h0);
    step();
    check_eq("t4_gnt", obs_gnt, 2'b10);
    check_eq("t4_s_req", obs_sreq, 4'b0000);
    check_eq("t4_err", m_err_o, 2'b10);
    check_eq("t4_rdata", m_rdata_o[63:32], 32'h0);

    // Back-to-back reads.
    setm(1, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      setm(0, 1'b1, DAW'(i*4), 1'b0, 4'hF, 32'h0);
      step();
      check_eq("t5_rvalid", m_rvalid_o[0], 1'b1);
      check_eq("t5_rdata", m_rdata_o[31:0], ref_mem[i]);
    end
    idle_all(); step();

    // Reset while a response is pending; pointer must return to master 0.
    setm(0, 1'b1, 14'h1000, 1'b0, 4'hF, 32'h0); step();
    idle_all();
    setm(1, 1'b1, 14'h1800, 1'b0, 4'hF, 32'h0); step();
    rst_cycle();
    setm(0, 1'b1, 14'h1000, 1'b0, 4'hF, 32'h0);
    setm(1, 1'b1, 14'h1004, 1'b0, 4'hF, 32'h0);
    step();
    check_eq("t6_gnt_after_rst", obs_gnt, 2'b01);
    idle_all(); step();

    // Randomized traffic with OBI hold-until-grant behaviour.
    for (int c = 0; c < 500; c++) begin
      for (int m = 0; m < NCORE; m++) begin
        if (!m_req_i[m] || mdl_gnt[m]) begin
          logic [DAW-1:0] a;
          logic [3:0] be;
          if ($urandom_range(9, 0) == 0) a = DAW'(14'h2000 | ($urandom_range(2047, 0) * 4));
          else a = DAW'($urandom_range(NSRAM-1, 0) * BANK_BYTES + $urandom_range(7, 0) * 4);
          be = 4'($urandom_range(15, 1));
          setm(m, $urandom_range(3, 0) != 0, a, 1'($urandom), be, $urandom);
        end
      end
      step();
    end
    idle_all(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
